imm_extend_pipe: RTL

Parametrised, registered immediate-extension stage for the KGP-RISC datapath. It generalises the fixed 26→32 sign extender to any input/output width and adds four modes: sign-extend, zero-extend, scaled sign-extend and PC-relative target. Results pass through a 2-entry elastic buffer with valid/ready handshakes, so the block sits between decode and execute/branch-target logic and absorbs one cycle of downstream stall.

---
 rtl/imm_extend_pipe_if.sv | 26 ++
 rtl/imm_extend_pipe.sv | 102 ++++++++++
 2 files changed

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: request side (decode) and result side (execute).
// The master modport is the environment; the slave modport is the extension stage.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [OUT_W-1:0] in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_imm, in_mode, in_pc, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_pc, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate extension (sign/zero/scaled/PC-relative) feeding a 2-entry
// elastic FIFO. in_ready depends only on the stored count, never on out_ready.
module imm_extend_pipe #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  imm_extend_pipe_if.slave    bus
);

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_shf;
  logic [OUT_W-1:0] w_result;
  logic [SHAMT:0]   w_top;
  logic             w_scale_ovf;
  logic             w_ovf;
  logic             w_push;
  logic             w_pop;

  logic [OUT_W:0]   r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_ext
      if (gi < IN_W) begin : g_in
        assign w_sext[gi] = bus.in_imm[gi];
        assign w_zext[gi] = bus.in_imm[gi];
      end else begin : g_pad
        assign w_sext[gi] = bus.in_imm[IN_W-1];
        assign w_zext[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_shf = w_sext << SHAMT;

  // Scaling is lossless only when every bit shifted out matches the new sign bit.
  assign w_top       = w_sext[OUT_W-1 -: SHAMT+1];
  assign w_scale_ovf = !((&w_top) || !(|w_top));

  always_comb begin
    w_result = w_sext;
    w_ovf    = 1'b0;
    case (bus.in_mode)
      2'b00: w_result = w_sext;
      2'b01: w_result = w_zext;
      2'b10: begin
        w_result = w_shf;
        w_ovf    = w_scale_ovf;
      end
      default: begin
        w_result = bus.in_pc + w_shf;
        w_ovf    = w_scale_ovf;
      end
    endcase
  end

  assign bus.in_ready  = (r_count != 2'd2);
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_mem[r_rptr][OUT_W-1:0];
  assign bus.out_ovf   = r_mem[r_rptr][OUT_W];

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      // Stored data is left in place; only occupancy and pointers are cleared.
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_ovf, w_result};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
